// File: rtl/elastic_pipe_register.sv
// rtl/elastic_pipe_register.sv - Depth-entry elastic buffer between two pipeline stages
// Circular store with valid/ready on both sides, synchronous flush and occupancy output.
module elastic_pipe_register #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_input,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_output,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] occ;
    logic             push;
    logic             pop;

    // Pointers wrap at DEPTH-1 so non power-of-two depths never index past the store.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake outputs depend only on registered occupancy, never on out_ready.
    assign in_ready    = (occ < CNT_W'(DEPTH));
    assign out_valid   = (occ != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign data_output = out_valid ? mem[rp] : '0;
    assign count       = occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                wp <= bump(wp);
            end
            if (pop) begin
                rp <= bump(rp);
            end
            if (push && !pop) begin
                occ <= occ + CNT_W'(1);
            end else if (pop && !push) begin
                occ <= occ - CNT_W'(1);
            end
        end
    end

    // Flush leaves stored words in place; only reset scrubs them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wp] <= data_input;
        end
    end

endmodule

// File: doc/elastic_pipe_register.md
# elastic_pipe_register

- **Purpose:** parametrised successor to the processor's plain pipeline register.
- **Datapath:** Width-bit words pass between two pipeline stages through a Depth-entry elastic buffer.
- **Handshake:** valid/ready on both sides.
- **Flush:** synchronous flush for branch/exception squash.
- **Status:** occupancy output.
- **Placement:** sits between processor pipeline stages wherever a stage can stall independently of its producer.

## Interface
- Width, 32, data word width in bits (≥1)
- Depth, 2, number of buffer entries (1..16, any integer, not only powers of two)
- CLK  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately
- Flush  in  1  synchronous squash of all buffered entries
- InValid  in  1  producer presents a word on DataInput
- InReady  out  1  buffer can accept a word this cycle
- DataInput  in  Width  producer word
- OutValid  out  1  DataOutput holds a valid word
- OutReady  in  1  consumer accepts DataOutput this cycle
- DataOutput  out  Width  oldest buffered word
- Count  out  clog2(Depth+1)  number of occupied entries

## Operation
- **Storage:** circular array of Depth words, write pointer wp, read pointer rp, occupancy count.
- **Push:** InValid && InReady at a rising edge. mem[wp] ← DataInput, then wp advances.
- **Pop:** OutValid && OutReady at a rising edge. rp advances.
- **Pointer wrap:** each pointer goes from Depth-1 to 0. Pointers never exceed Depth-1.
- **Count update:** +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- **InReady:** = (count < Depth). Depends only on state, with no combinational path from OutReady.
- **OutValid:** = (count != 0).
- **DataOutput:** = mem[rp] when OutValid=1, else all zeros.
- **Count output:** = count.
- **Ignored requests:** InValid while InReady=0 is ignored, with no overwrite. OutReady while OutValid=0 is ignored, with no underflow.
- **Flush:** at the next edge, count, wp and rp all go to 0. A push or pop in the same cycle is discarded. Flush has priority over both. Memory contents are not cleared.
- **Reset (Reset=0):** asynchronous, effective mid-operation with no clock.
  - count, wp, rp and all memory words go to 0.
  - Resulting outputs: InReady=1, OutValid=0, DataOutput=0, Count=0.
  - State is held at 0 while Reset=0.
  - Release is synchronous to CLK. The first push is accepted at the first rising edge with Reset=1.

## Timing
- **Latency:** a word pushed at edge N appears on DataOutput with OutValid=1 after edge N. There is no combinational DataInput→DataOutput path.
- **Throughput, Depth≥2:** one word per cycle sustained with InValid=OutReady=1.
- **Throughput, Depth=1:**
  - When full, InReady=0, so push and pop never coincide.
  - Peak throughput is one word per two cycles. This is the defined behaviour.
- **Outputs:** InReady, OutValid and Count are pure functions of registered state. DataOutput is a registered word muxed by rp, gated by OutValid.
- **Full state:** with OutReady=1 held, the buffer pops at the next edge, and InReady returns to 1 after that edge.
- **Simultaneous push and pop:** with 0<count<Depth, count is unchanged and both pointers advance.

## Test plan
- **Reset state:** assert Reset=0 asynchronously mid-cycle with count=2. Immediately InReady=1, OutValid=0, DataOutput=0, Count=0. The first push after release is 0x0000_00A1, visible on DataOutput one edge later.
- **Fill to full:** Depth=2, OutReady=0, push 0x11, 0x22, 0x33 on consecutive cycles. Count goes 1 then 2, and InReady=0 after the second edge. 0x33 is rejected. Then OutReady=1 pops 0x11, then 0x22, and Count returns to 0.
- **Streaming:** Depth=2, InValid=OutReady=1, push 0x01..0x08 on consecutive edges. DataOutput shows 0x01..0x08 on consecutive cycles, one edge after each push. Count stays 1 and nothing is lost.
- **Pointer wrap:** Depth=3, perform 7 pushes interleaved with pops so wp and rp wrap twice. Order is preserved FIFO, Count never exceeds 3, and wp=rp when Count=0.
- **Flush priority:** count=2 with Flush=1, InValid=1 and OutReady=1 in the same cycle. After the edge Count=0, OutValid=0, DataOutput=0. The pushed word never appears.
- **Depth=1 throughput:** InValid=OutReady=1 continuous. OutValid toggles 0/1 each cycle, giving one word per two cycles, and InReady is the inverse of OutValid.
